// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serial transmitter with a circular FIFO.
// Ports: Clk, Reset (sync, high), data_in/WR in; TX, busy, full, empty, ovf out.
module uart_tx #(
  parameter int unsigned BAUD_DIV = 2603,
  parameter int unsigned DEPTH    = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] data_in,
  input  logic       WR,
  output logic       TX,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [12:0] BAUD_LAST = 13'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e      state_q;
  logic [12:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          ovf_q;

  logic baud_wrap;
  logic pop;
  logic push;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign baud_wrap = (baud_q == BAUD_LAST);

  // Head is consumed on leaving IDLE or at the end of a stop bit.
  assign pop  = !empty &&
                ((state_q == IDLE) ||
                 ((state_q == STOP) && baud_wrap));
  // Full is the registered state: a write at full drops even if a pop
  // frees a slot in the same cycle.
  assign push = WR && !full;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_q] <= data_in;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (WR && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // TX is registered from the current state, so the line trails the
  // state by one cycle; every bit still lasts BAUD_DIV cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (!empty) begin
            shift_q <= mem_q[rd_q];
            state_q <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (baud_wrap) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          tx_q <= shift_q[0];
          if (baud_wrap) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (baud_wrap) begin
            baud_q <= '0;
            if (!empty) begin
              shift_q <= mem_q[rd_q];
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          baud_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign TX   = tx_q;
  assign busy = (state_q != IDLE);
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random and directed stimulus for uart_tx against a
// frame-position model of the serial line and a byte queue.
module tb_uart_tx;

  localparam int B = 4;
  localparam int D = 4;
  localparam int FR = 10 * B;

  logic       clk;
  logic       rst;
  logic       wr;
  logic [7:0] din;
  logic       tx;
  logic       busy;
  logic       full;
  logic       empty;
  logic       ovf;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx #(
    .BAUD_DIV(B),
    .DEPTH   (D)
  ) dut (
    .Clk    (clk),
    .Reset  (rst),
    .data_in(din),
    .WR     (wr),
    .TX     (tx),
    .busy   (busy),
    .full   (full),
    .empty  (empty),
    .ovf    (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: queue of pending bytes plus the position inside the frame
  // currently being sent (-1 when idle).
  logic [7:0] mq [$];
  int         mpos = -1;
  logic [7:0] mcur = 8'h00;
  logic [7:0] mnb;
  int         mn;
  bit         mpop;
  logic       e_tx = 1'b1;
  bit         m_ovf = 1'b0;
  bit         chk_en = 1'b0;

  function automatic logic line(int p, logic [7:0] c);
    if (p < 0) return 1'b1;
    if (p < B) return 1'b0;
    if (p < 9 * B) return c[3'((p - B) / B)];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mpos  = -1;
      m_ovf = 1'b0;
      e_tx  = 1'b1;
    end else begin
      mn   = mq.size();
      mpop = (mn > 0) && ((mpos < 0) || (mpos == FR - 1));
      e_tx = line(mpos, mcur);
      mnb  = 8'h00;
      if (mpop) mnb = mq.pop_front();
      if (wr) begin
        if (mn == D) m_ovf = 1'b1;
        else mq.push_back(din);
      end
      if (mpop) begin
        mpos = 0;
        mcur = mnb;
      end else if (mpos == FR - 1) begin
        mpos = -1;
      end else if (mpos >= 0) begin
        mpos++;
      end
    end
  end

  task automatic check(string nm, logic got, logic want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0b want=%0b t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic checkv(string nm, logic [19:0] got, logic [19:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", tx, e_tx);
      check("busy", busy, mpos >= 0);
      check("full", full, mq.size() == D);
      check("empty", empty, mq.size() == 0);
      check("ovf", ovf, m_ovf);
    end
  end

  logic cap [0:95];

  task automatic capture(int n);
    cap[0] = tx;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      cap[i] = tx;
    end
  endtask

  function automatic logic [19:0] mids(int nb);
    logic [19:0] v;
    v = '0;
    for (int k = 0; k < nb; k++) v[k] = cap[4 * k + 2];
    return v;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || !empty) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= 2000) begin
      n_err++;
      $display("FAIL idle_timeout got=busy want=idle t=%0t", $time);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(bit with_wr);
    @(negedge clk);
    rst = 1'b1;
    wr  = with_wr;
    din = 8'h77;
    @(negedge clk);
    rst = 1'b0;
    wr  = 1'b0;
  endtask

  // Leaves the caller on the first cycle of TX=0 for the byte.
  task automatic write_lat(logic [7:0] b, string nm);
    wr  = 1'b1;
    din = b;
    @(negedge clk);
    wr = 1'b0;
    check({nm, "_lat_n"}, tx, 1'b1);
    @(negedge clk);
    check({nm, "_lat_n1"}, tx, 1'b1);
    @(negedge clk);
    check({nm, "_lat_n2"}, tx, 1'b0);
  endtask

  int pct;

  initial begin
    rst = 1'b1;
    wr  = 1'b0;
    din = 8'h00;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    // Write while reset is high is discarded.
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    check("rstwr_empty", empty, 1'b1);
    check("rstwr_busy", busy, 1'b0);
    check("rstwr_tx", tx, 1'b1);

    // Single 0xA5 frame.
    write_lat(8'hA5, "a5");
    capture(40);
    checkv("a5_bits", mids(10), 20'(10'b1101001010));
    @(negedge clk);
    check("a5_end_tx", tx, 1'b1);
    check("a5_end_busy", busy, 1'b0);
    check("a5_end_empty", empty, 1'b1);

    // Back-to-back 0x55, 0x0F.
    wait_idle();
    wr  = 1'b1;
    din = 8'h55;
    @(negedge clk);
    din = 8'h0F;
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    capture(80);
    checkv("b2b_bits", mids(20), 20'b1000011110_1010101010);
    check("b2b_gap", cap[40], 1'b0);
    check("b2b_stop", cap[39], 1'b1);

    // Six consecutive writes from idle: the sixth is dropped.
    wait_idle();
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      wr  = 1'b1;
      din = 8'(8'h10 + i);
      @(negedge clk);
      if (i == 4) check("burst_full", full, 1'b1);
    end
    wr = 1'b0;
    check("burst_ovf", ovf, 1'b1);
    wait_idle();
    check("burst_ovf_sticky", ovf, 1'b1);

    // Hold WR at full across a stop-bit pop.
    do_reset(1'b0);
    for (int i = 0; i < 50; i++) begin
      wr  = 1'b1;
      din = 8'($urandom);
      @(negedge clk);
    end
    wr = 1'b0;
    check("stopfull_ovf", ovf, 1'b1);
    wait_idle();

    // Reset at cycle 17 of a 0x3C frame, then 0x81.
    do_reset(1'b0);
    write_lat(8'h3C, "3c");
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_empty", empty, 1'b1);
    @(negedge clk);
    write_lat(8'h81, "81");
    capture(40);
    checkv("81_bits", mids(10), 20'(10'b1100000010));

    // Random traffic with varying write density and rare resets.
    wait_idle();
    for (int s = 0; s < 8; s++) begin
      pct = (s % 3 == 0) ? 2 : ((s % 3 == 1) ? 6 : 45);
      for (int i = 0; i < 500; i++) begin
        wr  = ($urandom_range(0, 99) < pct);
        din = 8'($urandom);
        rst = ($urandom_range(0, 1499) == 0);
        @(negedge clk);
      end
    end
    wr  = 1'b0;
    rst = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
